axis_frame_fifo_param: RTL and testbench

AXIS_FRAME_FIFO_PARAM -- requirements
Module: axis_frame_fifo_param

---
 rtl/axis_frame_fifo_param_if.sv | 14 +
 rtl/axis_frame_fifo_param.sv | 131 +++++++++++++
 tb/tb_axis_frame_fifo_param.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_fifo_param_if.sv
// AXI-Stream style handshake bundle shared by both sides of the frame FIFO.
// The master drives data, valid, last and user, and the slave answers with tready.
interface axis_frame_fifo_param_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic                  tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_fifo_param.sv
// Frame FIFO: words are held back until their frame's tlast commits them, and
// frames that overflow or end flagged bad are rewound and never reach the output.
module axis_frame_fifo_param #(
   parameter int   ADDR_WIDTH           = 4,
   parameter int   DATA_WIDTH           = 8,
   parameter bit   DROP_WHEN_FULL       = 1'b1,
   parameter bit   DROP_BAD_FRAME       = 1'b0,
   parameter logic USER_BAD_FRAME_VALUE = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   axis_frame_fifo_param_if.slave         input_axis,
   axis_frame_fifo_param_if.master        output_axis,
   output logic                           drop_frame,
   output logic                           overflow,
   output logic                           bad_frame,
   output logic                           good_frame
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   typedef logic [ADDR_WIDTH:0] ptr_t;
   localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);
   localparam ptr_t ONE_PTR   = ptr_t'(1);

   logic [DATA_WIDTH:0] mem [DEPTH];

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t wr_ptr_cur_q, wr_ptr_cur_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   logic drop_frame_q, drop_frame_d;
   logic overflow_q, overflow_d;
   logic bad_frame_q, bad_frame_d;
   logic good_frame_q, good_frame_d;
   logic out_valid_q, out_valid_d;
   logic out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic full;
   logic empty;
   logic in_ready;
   logic mem_we;

   // full counts speculative words; empty only counts committed ones, so the read side never sees a partial frame
   assign full     = (wr_ptr_cur_q - rd_ptr_q) == DEPTH_PTR;
   assign empty    = wr_ptr_q == rd_ptr_q;
   assign in_ready = DROP_WHEN_FULL ? 1'b1 : ~full;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      wr_ptr_cur_d = wr_ptr_cur_q;
      drop_frame_d = drop_frame_q;
      overflow_d   = 1'b0;
      bad_frame_d  = 1'b0;
      good_frame_d = 1'b0;
      mem_we       = 1'b0;
      if (input_axis.tvalid && in_ready) begin
         if (drop_frame_q) begin
            if (input_axis.tlast) drop_frame_d = 1'b0;
         end else if (DROP_WHEN_FULL && full) begin
            wr_ptr_cur_d = wr_ptr_q;
            overflow_d   = 1'b1;
            drop_frame_d = ~input_axis.tlast;
         end else begin
            mem_we       = 1'b1;
            wr_ptr_cur_d = wr_ptr_cur_q + ONE_PTR;
            if (input_axis.tlast) begin
               if (DROP_BAD_FRAME && (input_axis.tuser == USER_BAD_FRAME_VALUE)) begin
                  wr_ptr_cur_d = wr_ptr_q;
                  bad_frame_d  = 1'b1;
               end else begin
                  wr_ptr_d     = wr_ptr_cur_q + ONE_PTR;
                  good_frame_d = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (!empty && (!out_valid_q || output_axis.tready)) begin
         {out_last_d, out_data_d} = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
         rd_ptr_d    = rd_ptr_q + ONE_PTR;
         out_valid_d = 1'b1;
      end else if (output_axis.tready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_cur_q[ADDR_WIDTH-1:0]] <= {input_axis.tlast, input_axis.tdata};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         wr_ptr_cur_q <= '0;
         rd_ptr_q     <= '0;
         drop_frame_q <= 1'b0;
         overflow_q   <= 1'b0;
         bad_frame_q  <= 1'b0;
         good_frame_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         wr_ptr_cur_q <= wr_ptr_cur_d;
         rd_ptr_q     <= rd_ptr_d;
         drop_frame_q <= drop_frame_d;
         overflow_q   <= overflow_d;
         bad_frame_q  <= bad_frame_d;
         good_frame_q <= good_frame_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
      end
   end

   assign input_axis.tready  = in_ready;
   assign output_axis.tdata  = out_data_q;
   assign output_axis.tvalid = out_valid_q;
   assign output_axis.tlast  = out_last_q;
   assign output_axis.tuser  = 1'b0;
   assign drop_frame         = drop_frame_q;
   assign overflow           = overflow_q;
   assign bad_frame          = bad_frame_q;
   assign good_frame         = good_frame_q;
endmodule

// File: tb/tb_axis_frame_fifo_param.sv
// Bench for the frame FIFO: two configurations share one stimulus stream and a
// queue-based frame model; the selected instance is compared every cycle.
module tb_axis_frame_fifo_param;
   localparam int AW    = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] t_data;
   logic       t_valid, t_last, t_user, o_ready;
   bit         sel;

   always #5 clk = ~clk;

   axis_frame_fifo_param_if #(.DATA_WIDTH(DW)) in_a ();
   axis_frame_fifo_param_if #(.DATA_WIDTH(DW)) out_a ();
   axis_frame_fifo_param_if #(.DATA_WIDTH(DW)) in_b ();
   axis_frame_fifo_param_if #(.DATA_WIDTH(DW)) out_b ();

   assign in_a.tdata  = t_data;
   assign in_a.tvalid = t_valid;
   assign in_a.tlast  = t_last;
   assign in_a.tuser  = t_user;
   assign out_a.tready = o_ready;
   assign in_b.tdata  = t_data;
   assign in_b.tvalid = t_valid;
   assign in_b.tlast  = t_last;
   assign in_b.tuser  = t_user;
   assign out_b.tready = o_ready;

   logic drop_a, ovf_a, bad_a, good_a;
   logic drop_b, ovf_b, bad_b, good_b;

   axis_frame_fifo_param #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_WHEN_FULL(1'b1),
      .DROP_BAD_FRAME(1'b1), .USER_BAD_FRAME_VALUE(1'b1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .input_axis(in_a), .output_axis(out_a),
      .drop_frame(drop_a), .overflow(ovf_a), .bad_frame(bad_a), .good_frame(good_a)
   );

   axis_frame_fifo_param #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DROP_WHEN_FULL(1'b0),
      .DROP_BAD_FRAME(1'b0), .USER_BAD_FRAME_VALUE(1'b1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .input_axis(in_b), .output_axis(out_b),
      .drop_frame(drop_b), .overflow(ovf_b), .bad_frame(bad_b), .good_frame(good_b)
   );

   logic       s_tready, s_ovalid, s_olast, s_drop, s_ovf, s_bad, s_good;
   logic [7:0] s_odata;

   always_comb begin
      if (sel) begin
         s_tready = in_b.tready;  s_ovalid = out_b.tvalid; s_olast = out_b.tlast;
         s_odata  = out_b.tdata;  s_drop = drop_b; s_ovf = ovf_b; s_bad = bad_b; s_good = good_b;
      end else begin
         s_tready = in_a.tready;  s_ovalid = out_a.tvalid; s_olast = out_a.tlast;
         s_odata  = out_a.tdata;  s_drop = drop_a; s_ovf = ovf_a; s_bad = bad_a; s_good = good_a;
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: committed frames waiting to be read, the frame still being written, and the output register
   logic [8:0] m_fifo[$];
   logic [8:0] m_part[$];
   bit         m_drop, m_ov, m_ol, m_ovf, m_bad, m_good, m_dwf, m_dbf;
   logic [7:0] m_od;

   function automatic bit m_full();
      return (m_fifo.size() + m_part.size()) == DEPTH;
   endfunction

   function automatic bit m_ready();
      return m_dwf || !m_full();
   endfunction

   task automatic m_reset();
      m_fifo.delete();
      m_part.delete();
      m_drop = 0; m_ov = 0; m_ol = 0; m_ovf = 0; m_bad = 0; m_good = 0;
      m_od = 8'h00;
   endtask

   task automatic m_edge();
      bit         full_pre;
      bit         rdy;
      logic [8:0] w;
      full_pre = m_full();
      rdy      = m_ready();
      m_ovf = 0; m_bad = 0; m_good = 0;
      if (m_fifo.size() != 0 && (!m_ov || o_ready)) begin
         w    = m_fifo.pop_front();
         m_ov = 1;
         m_od = w[7:0];
         m_ol = w[8];
      end else if (o_ready) begin
         m_ov = 0;
      end
      if (t_valid && rdy) begin
         if (m_drop) begin
            if (t_last) m_drop = 0;
         end else if (m_dwf && full_pre) begin
            m_part.delete();
            m_ovf  = 1;
            m_drop = !t_last;
         end else begin
            m_part.push_back({t_last, t_data});
            if (t_last) begin
               if (m_dbf && t_user) begin
                  m_part.delete();
                  m_bad = 1;
               end else begin
                  while (m_part.size() != 0) m_fifo.push_back(m_part.pop_front());
                  m_good = 1;
               end
            end
         end
      end
   endtask

   task automatic checkOutput();
      check("tready",   s_tready, m_ready());
      check("ovalid",   s_ovalid, m_ov);
      check("odata",    s_odata,  m_od);
      check("olast",    s_olast,  m_ol);
      check("drop",     s_drop,   m_drop);
      check("overflow", s_ovf,    m_ovf);
      check("bad",      s_bad,    m_bad);
      check("good",     s_good,   m_good);
   endtask

   task automatic applyStimulus(logic [7:0] d, logic v, logic l, logic u, logic r);
      t_data = d; t_valid = v; t_last = l; t_user = u; o_ready = r;
      m_edge();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic doReset();
      t_data = 8'h00; t_valid = 1'b0; t_last = 1'b0; t_user = 1'b0;
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_drop",   s_drop,   1'b0);
      check("rst_ovalid", s_ovalid, 1'b0);
      checkOutput();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic       rst;
      logic [7:0] data;
      logic       valid, last, user, oready;
      logic       e_ovalid;
      logic [7:0] e_odata;
      logic       e_olast, e_drop, e_ovf, e_good;
   } vec_t;

   function automatic vec_t mk(logic rst, logic [7:0] d, logic v, logic l, logic u, logic r,
                               logic ev, logic [7:0] ed, logic el, logic edr, logic eo, logic eg);
      vec_t x;
      x.rst = rst; x.data = d; x.valid = v; x.last = l; x.user = u; x.oready = r;
      x.e_ovalid = ev; x.e_odata = ed; x.e_olast = el; x.e_drop = edr; x.e_ovf = eo; x.e_good = eg;
      return x;
   endfunction

   vec_t tbl[$];
   logic [7:0] bp_d[6] = '{8'h30, 8'h30, 8'h31, 8'h31, 8'h32, 8'h32};
   logic       bp_l[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic       bp_r[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [7:0] nd;
      logic       nv, nl, nu, nr, acc;
      int         pos, flen, maxlen;

      t_data = 0; t_valid = 0; t_last = 0; t_user = 0; o_ready = 0;
      sel = 0; m_dwf = 1; m_dbf = 1;
      rst_n = 1'b1;
      #3;

      // pass-through then overflow, expected values worked out by hand
      tbl.push_back(mk(1, 8'h01, 1, 1, 0, 1,  0, 8'h00, 0,  0, 0, 1));
      tbl.push_back(mk(0, 8'h02, 1, 1, 0, 1,  1, 8'h01, 1,  0, 0, 1));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 8'h02, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0,  0, 0, 0));
      tbl.push_back(mk(1, 8'h01, 1, 1, 0, 0,  0, 8'h00, 0,  0, 0, 1));
      tbl.push_back(mk(0, 8'h02, 1, 1, 0, 0,  1, 8'h01, 1,  0, 0, 1));
      tbl.push_back(mk(0, 8'h04, 1, 1, 0, 0,  1, 8'h01, 1,  0, 0, 1));
      tbl.push_back(mk(0, 8'h05, 1, 0, 0, 0,  1, 8'h01, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h06, 1, 0, 0, 0,  1, 8'h01, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h07, 1, 0, 0, 0,  1, 8'h01, 1,  1, 1, 0));
      tbl.push_back(mk(0, 8'h08, 1, 1, 0, 0,  1, 8'h01, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 8'h02, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 8'h04, 1,  0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 8'h00, 0,  0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) doReset();
         applyStimulus(tbl[i].data, tbl[i].valid, tbl[i].last, tbl[i].user, tbl[i].oready);
         check("tbl_ovalid", s_ovalid, tbl[i].e_ovalid);
         if (tbl[i].e_ovalid) begin
            check("tbl_odata", s_odata, tbl[i].e_odata);
            check("tbl_olast", s_olast, tbl[i].e_olast);
         end
         check("tbl_drop", s_drop, tbl[i].e_drop);
         check("tbl_ovf",  s_ovf,  tbl[i].e_ovf);
         check("tbl_good", s_good, tbl[i].e_good);
      end

      // reset while a frame is being dropped
      doReset();
      applyStimulus(8'h3F, 1, 1, 0, 0);
      applyStimulus(8'h40, 1, 0, 0, 0);
      applyStimulus(8'h41, 1, 0, 0, 0);
      applyStimulus(8'h42, 1, 0, 0, 0);
      applyStimulus(8'h43, 1, 0, 0, 0);
      applyStimulus(8'h44, 1, 0, 0, 0);
      check("rd_drop",  s_drop,  1'b1);
      check("rd_ovf",   s_ovf,   1'b1);
      check("rd_odata", s_odata, 8'h3F);
      doReset();
      check("rd_after_odata", s_odata, 8'h00);
      applyStimulus(8'h07, 1, 1, 0, 1);
      check("rd_good", s_good, 1'b1);
      applyStimulus(8'h00, 0, 0, 0, 1);
      check("rd_ovalid", s_ovalid, 1'b1);
      check("rd_out",    s_odata,  8'h07);

      // bad frame discarded, following good frame kept
      doReset();
      applyStimulus(8'h10, 1, 0, 0, 1);
      applyStimulus(8'h11, 1, 1, 1, 1);
      check("bf_bad",  s_bad,  1'b1);
      check("bf_good", s_good, 1'b0);
      applyStimulus(8'h20, 1, 1, 0, 1);
      check("bf_good2",  s_good,   1'b1);
      check("bf_ovalid", s_ovalid, 1'b0);
      applyStimulus(8'h00, 0, 0, 0, 1);
      check("bf_out",  s_odata, 8'h20);
      check("bf_last", s_olast, 1'b1);
      applyStimulus(8'h00, 0, 0, 0, 1);
      check("bf_empty", s_ovalid, 1'b0);

      // stall configuration: input backpressure instead of dropping
      sel = 1; m_dwf = 0; m_dbf = 0;
      doReset();
      applyStimulus(8'hA0, 1, 0, 0, 0);
      check("st_rdy0", s_tready, 1'b1);
      applyStimulus(8'hA1, 1, 0, 0, 0);
      applyStimulus(8'hA2, 1, 0, 0, 0);
      applyStimulus(8'hA3, 1, 1, 0, 0);
      check("st_full",  s_tready, 1'b0);
      check("st_good",  s_good,   1'b1);
      applyStimulus(8'hA4, 1, 1, 0, 0);
      check("st_rdy1",  s_tready, 1'b1);
      check("st_out0",  s_odata,  8'hA0);
      applyStimulus(8'hA4, 1, 1, 0, 0);
      check("st_full2", s_tready, 1'b0);
      applyStimulus(8'hA5, 1, 1, 0, 0);
      applyStimulus(8'hA5, 1, 1, 0, 0);
      check("st_hold",  s_tready, 1'b0);
      check("st_hold_d", s_odata, 8'hA0);
      applyStimulus(8'hA5, 1, 1, 0, 1);
      check("st_rise",  s_tready, 1'b1);
      check("st_out1",  s_odata,  8'hA1);
      check("st_nogood", s_good,  1'b0);
      applyStimulus(8'hA5, 1, 1, 0, 1);
      check("st_acc",   s_good,   1'b1);
      check("st_out2",  s_odata,  8'hA2);

      // output backpressure across one three-word frame
      sel = 0; m_dwf = 1; m_dbf = 1;
      doReset();
      applyStimulus(8'h30, 1, 0, 0, 1);
      applyStimulus(8'h31, 1, 0, 0, 1);
      applyStimulus(8'h32, 1, 1, 0, 1);
      check("bp_good", s_good, 1'b1);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(8'h00, 0, 0, 0, bp_r[i]);
         if (i < 6) begin
            check("bp_ovalid", s_ovalid, 1'b1);
            check("bp_odata",  s_odata,  bp_d[i]);
            check("bp_olast",  s_olast,  bp_l[i]);
         end else begin
            check("bp_done", s_ovalid, 1'b0);
         end
      end

      // random frames against the model, first the dropping instance then the stalling one
      for (int p = 0; p < 2; p++) begin
         sel    = (p == 1);
         m_dwf  = (p == 0);
         m_dbf  = (p == 0);
         maxlen = (p == 0) ? 6 : DEPTH;
         doReset();
         pos = 0;
         flen = $urandom_range(1, maxlen);
         nv = 0; nd = 0; nl = 0; nu = 0;
         for (int c = 0; c < 1500; c++) begin
            if (!(nv && !m_ready())) begin
               nv = ($urandom_range(0, 3) != 0);
               nd = 8'($urandom);
               nl = nv && (pos + 1 >= flen);
               nu = ($urandom_range(0, 3) == 0);
            end
            nr  = ($urandom_range(0, 2) != 0);
            acc = nv && m_ready();
            applyStimulus(nd, nv, nl, nu, nr);
            if (acc) begin
               if (nl) begin
                  pos  = 0;
                  flen = $urandom_range(1, maxlen);
               end else begin
                  pos++;
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
